// File: rtl/qpi_psram_responder.sv
// rtl/qpi_psram_responder.sv - device-side QPI PSRAM responder with internal byte array
//
// Ports:
//   mem_clk   PSRAM serial clock; inputs sampled on posedge, bus driven on negedge
//   rst_n     asynchronous active-low reset
//   mem_ce    chip enable, active low; high ends/aborts the current frame
//   mem_sio   4-bit bidirectional data bus; driven only during read data slots
//   qpi_mode  1 = QPI (nibble-wide) protocol active
//   rst_en    reset-enable latch (0x66 seen, waiting for 0x99)
//   err       sticky unsupported-command flag
//   wr_bytes  running count of bytes committed by writes (wraps)

module qpi_psram_responder #(
    parameter int ADDR_W    = 10,
    parameter int DATA_SLOT = 14
) (
    input  logic        mem_clk,
    input  logic        rst_n,
    input  logic        mem_ce,
    inout  wire  [3:0]  mem_sio,
    output logic        qpi_mode,
    output logic        rst_en,
    output logic        err,
    output logic [15:0] wr_bytes
);

    localparam int          DEPTH       = 1 << ADDR_W;
    localparam int          ASH_W       = ADDR_W - 4;
    localparam logic [5:0]  DATA_SLOT_L = 6'(DATA_SLOT);
    localparam logic [5:0]  SLOT_MAX    = 6'd63;

    // Deferred frame actions: commands only take effect once mem_ce rises,
    // so a frame aborted before its command completes changes nothing.
    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_RSTEN,
        ACT_RST,
        ACT_QPI_ON,
        ACT_QPI_OFF,
        ACT_ERR,
        ACT_CLR
    } act_t;

    typedef enum logic [1:0] {
        XF_IDLE,
        XF_WRITE,
        XF_READ
    } xfer_t;

    logic [7:0]        mem [DEPTH];

    logic [5:0]        slot;
    logic [6:0]        spi_sh;
    logic [3:0]        cmd_hi;
    logic [ASH_W-1:0]  addr_sh;
    logic [ADDR_W-1:0] ptr;
    logic              nib_sel;
    logic [3:0]        hi_nib;
    act_t              act;
    xfer_t             xfer;

    logic              sio_oe;
    logic [3:0]        sio_out;
    logic [3:0]        sio_in;
    logic              mem_we;

    assign mem_sio = sio_oe ? sio_out : 4'bz;
    assign sio_in  = mem_sio;

    // Second nibble of a write byte: commit the assembled byte this posedge.
    assign mem_we = rst_n && !mem_ce && (xfer == XF_WRITE) && (slot >= 6'd8) && nib_sel;

    always_ff @(posedge mem_clk) begin
        if (mem_we) begin
            mem[ptr] <= {hi_nib, sio_in};
        end
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            slot     <= 6'd0;
            spi_sh   <= 7'd0;
            cmd_hi   <= 4'd0;
            addr_sh  <= '0;
            ptr      <= '0;
            nib_sel  <= 1'b0;
            hi_nib   <= 4'd0;
            act      <= ACT_NONE;
            xfer     <= XF_IDLE;
            qpi_mode <= 1'b0;
            rst_en   <= 1'b0;
            err      <= 1'b0;
            wr_bytes <= 16'd0;
        end else if (mem_ce) begin
            slot    <= 6'd0;
            xfer    <= XF_IDLE;
            nib_sel <= 1'b0;
            act     <= ACT_NONE;
            case (act)
                ACT_RSTEN: rst_en <= 1'b1;
                ACT_RST: begin
                    if (rst_en) begin
                        qpi_mode <= 1'b0;
                        rst_en   <= 1'b0;
                        err      <= 1'b0;
                    end
                end
                ACT_QPI_ON: begin
                    qpi_mode <= 1'b1;
                    rst_en   <= 1'b0;
                end
                ACT_QPI_OFF: begin
                    qpi_mode <= 1'b0;
                    rst_en   <= 1'b0;
                end
                ACT_ERR: err    <= 1'b1;
                ACT_CLR: rst_en <= 1'b0;
                default: ;
            endcase
        end else begin
            slot <= (slot == SLOT_MAX) ? SLOT_MAX : slot + 6'd1;
            if (!qpi_mode) begin
                if (slot < 6'd7) begin
                    spi_sh <= {spi_sh[5:0], sio_in[0]};
                end else if (slot == 6'd7) begin
                    case ({spi_sh, sio_in[0]})
                        8'h66:   act <= ACT_RSTEN;
                        8'h99:   act <= ACT_RST;
                        8'h35:   act <= ACT_QPI_ON;
                        default: act <= ACT_ERR;
                    endcase
                end
            end else begin
                case (slot)
                    6'd0: cmd_hi <= sio_in;
                    6'd1: begin
                        case ({cmd_hi, sio_in})
                            8'h38: begin
                                xfer <= XF_WRITE;
                                act  <= ACT_CLR;
                            end
                            8'hEB: begin
                                xfer <= XF_READ;
                                act  <= ACT_CLR;
                            end
                            8'h66:   act <= ACT_RSTEN;
                            8'h99:   act <= ACT_RST;
                            8'hF5:   act <= ACT_QPI_OFF;
                            default: act <= ACT_ERR;
                        endcase
                    end
                    6'd2, 6'd3, 6'd4, 6'd5, 6'd6: begin
                        // Only the low ADDR_W address bits survive the shift.
                        addr_sh <= ASH_W'({addr_sh, sio_in});
                    end
                    6'd7: begin
                        ptr     <= {addr_sh, sio_in};
                        nib_sel <= 1'b0;
                    end
                    default: begin
                        if (xfer == XF_WRITE) begin
                            if (!nib_sel) begin
                                hi_nib  <= sio_in;
                                nib_sel <= 1'b1;
                            end else begin
                                ptr      <= ptr + ADDR_W'(1);
                                wr_bytes <= wr_bytes + 16'd1;
                                nib_sel  <= 1'b0;
                            end
                        end else if (xfer == XF_READ && slot >= DATA_SLOT_L) begin
                            // Each read slot consumes one nibble; move to the
                            // next byte after its low nibble has gone out.
                            nib_sel <= !nib_sel;
                            if (nib_sel) begin
                                ptr <= ptr + ADDR_W'(1);
                            end
                        end
                    end
                endcase
            end
        end
    end

    // slot holds the index of the upcoming slot here, so the nibble for
    // slot k is on the bus half a cycle before posedge k.
    always_ff @(negedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            sio_oe  <= 1'b0;
            sio_out <= 4'd0;
        end else begin
            sio_oe  <= !mem_ce && (xfer == XF_READ) && (slot >= DATA_SLOT_L);
            sio_out <= nib_sel ? mem[ptr][3:0] : mem[ptr][7:4];
        end
    end

endmodule

// File: tb/tb_qpi_psram_responder.sv
// tb/tb_qpi_psram_responder.sv - directed vector bench for qpi_psram_responder

module tb_qpi_psram_responder;

    logic        mem_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        mem_ce  = 1'b1;
    logic        qpi_mode;
    logic        rst_en;
    logic        err;
    logic [15:0] wr_bytes;
    wire  [3:0]  mem_sio;

    logic        tb_oe   = 1'b0;
    logic [3:0]  tb_dout = 4'd0;
    logic [3:0]  seen_val;
    logic        seen_oe;

    int total = 0;
    int bad   = 0;

    assign mem_sio = tb_oe ? tb_dout : 4'bz;

    always #5 mem_clk = ~mem_clk;

    qpi_psram_responder #(.ADDR_W(10), .DATA_SLOT(14)) dut (
        .mem_clk  (mem_clk),
        .rst_n    (rst_n),
        .mem_ce   (mem_ce),
        .mem_sio  (mem_sio),
        .qpi_mode (qpi_mode),
        .rst_en   (rst_en),
        .err      (err),
        .wr_bytes (wr_bytes)
    );

    typedef struct {
        logic        wr;
        logic [23:0] addr;
        logic [15:0] data;
        logic [15:0] expv;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, got, expv);
        end
    endtask

    // One slot: drive inputs just after negedge, sample the bus just before posedge.
    task automatic slot_drive(input logic [3:0] nib, input logic drv);
        @(negedge mem_clk);
        #1;
        mem_ce  = 1'b0;
        tb_oe   = drv;
        tb_dout = nib;
        #3;
        seen_val = mem_sio;
        seen_oe  = dut.sio_oe;
    endtask

    task automatic ce_high(input int n);
        repeat (n) begin
            @(negedge mem_clk);
            #1;
            mem_ce = 1'b1;
            tb_oe  = 1'b0;
        end
    endtask

    task automatic spi_cmd(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) slot_drive({3'b000, b[i]}, 1'b1);
        ce_high(2);
    endtask

    task automatic qpi_cmd_only(input logic [7:0] c);
        slot_drive(c[7:4], 1'b1);
        slot_drive(c[3:0], 1'b1);
        ce_high(2);
    endtask

    task automatic qpi_hdr(input logic [7:0] c, input logic [23:0] a);
        slot_drive(c[7:4], 1'b1);
        slot_drive(c[3:0], 1'b1);
        for (int i = 5; i >= 0; i--) slot_drive(a[i*4 +: 4], 1'b1);
    endtask

    task automatic qpi_write(input logic [23:0] a, input logic [15:0] d);
        qpi_hdr(8'h38, a);
        for (int i = 3; i >= 0; i--) slot_drive(d[i*4 +: 4], 1'b1);
        ce_high(2);
    endtask

    // Two-byte read; win_ok is cleared if the enable is wrong in any slot.
    task automatic qpi_read(input logic [23:0] a, output logic [15:0] got, output logic win_ok);
        got    = 16'd0;
        win_ok = 1'b1;
        qpi_hdr(8'hEB, a);
        for (int k = 8; k < 18; k++) begin
            slot_drive(4'd0, 1'b0);
            if (k < 14) begin
                if (seen_oe !== 1'b0) win_ok = 1'b0;
            end else begin
                if (seen_oe !== 1'b1) win_ok = 1'b0;
                got = {got[11:0], seen_val};
            end
        end
        ce_high(2);
    endtask

    logic [15:0] rd;
    logic        ok;

    initial begin
        vecs[0] = '{wr: 1'b1, addr: 24'h000010, data: 16'hA55A, expv: 16'd2};
        vecs[1] = '{wr: 1'b0, addr: 24'h000010, data: 16'h0000, expv: 16'hA55A};
        vecs[2] = '{wr: 1'b1, addr: 24'hFFC000, data: 16'hBEEF, expv: 16'd4};
        vecs[3] = '{wr: 1'b0, addr: 24'h000000, data: 16'h0000, expv: 16'hBEEF};
        vecs[4] = '{wr: 1'b1, addr: 24'h0003FF, data: 16'h1234, expv: 16'd6};
        vecs[5] = '{wr: 1'b0, addr: 24'h0003FF, data: 16'h0000, expv: 16'h1234};
        vecs[6] = '{wr: 1'b0, addr: 24'h000000, data: 16'h0000, expv: 16'h34EF};
        vecs[7] = '{wr: 1'b1, addr: 24'h000021, data: 16'h7777, expv: 16'd8};

        repeat (3) @(negedge mem_clk);
        #4;
        check("reset_qpi_mode", {31'd0, qpi_mode}, 32'd0);
        check("reset_rst_en",   {31'd0, rst_en},   32'd0);
        check("reset_err",      {31'd0, err},      32'd0);
        check("reset_wr_bytes", {16'd0, wr_bytes}, 32'd0);
        check("reset_oe",       {31'd0, dut.sio_oe}, 32'd0);
        rst_n = 1'b1;
        ce_high(2);

        spi_cmd(8'h66);
        check("init_66_rst_en", {31'd0, rst_en}, 32'd1);
        spi_cmd(8'h99);
        check("init_99_rst_en", {31'd0, rst_en}, 32'd0);
        check("init_99_qpi",    {31'd0, qpi_mode}, 32'd0);
        spi_cmd(8'h35);
        check("init_35_qpi",    {31'd0, qpi_mode}, 32'd1);
        check("init_35_rst_en", {31'd0, rst_en},   32'd0);
        check("init_35_err",    {31'd0, err},      32'd0);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].wr) begin
                qpi_write(vecs[i].addr, vecs[i].data);
                check($sformatf("vec%0d_wr_bytes", i), {16'd0, wr_bytes}, {16'd0, vecs[i].expv});
            end else begin
                qpi_read(vecs[i].addr, rd, ok);
                check($sformatf("vec%0d_rd_data", i), {16'd0, rd}, {16'd0, vecs[i].expv});
                check($sformatf("vec%0d_oe_window", i), {31'd0, ok}, 32'd1);
            end
        end

        // Abort after the third data nibble: first byte kept, half byte dropped.
        qpi_hdr(8'h38, 24'h000020);
        slot_drive(4'hC, 1'b1);
        slot_drive(4'h3, 1'b1);
        slot_drive(4'hD, 1'b1);
        ce_high(2);
        check("abort_wr_bytes", {16'd0, wr_bytes}, 32'd9);
        qpi_read(24'h000020, rd, ok);
        check("abort_rd_data", {16'd0, rd}, 32'h0000C377);

        qpi_cmd_only(8'hF5);
        check("exit_qpi", {31'd0, qpi_mode}, 32'd0);
        spi_cmd(8'h99);
        check("lone_99_err",    {31'd0, err},      32'd0);
        check("lone_99_rst_en", {31'd0, rst_en},   32'd0);
        check("lone_99_qpi",    {31'd0, qpi_mode}, 32'd0);
        spi_cmd(8'hAB);
        check("bad_spi_err", {31'd0, err}, 32'd1);
        spi_cmd(8'h66);
        check("err_66_rst_en", {31'd0, rst_en}, 32'd1);
        check("err_66_err",    {31'd0, err},    32'd1);
        spi_cmd(8'h99);
        check("err_99_err",    {31'd0, err},      32'd0);
        check("err_99_rst_en", {31'd0, rst_en},   32'd0);
        check("err_99_qpi",    {31'd0, qpi_mode}, 32'd0);

        spi_cmd(8'h35);
        ok = 1'b1;
        qpi_hdr(8'h12, 24'h000010);
        for (int k = 8; k < 18; k++) begin
            slot_drive(4'd0, 1'b0);
            if (seen_oe !== 1'b0) ok = 1'b0;
        end
        ce_high(2);
        check("bad_qpi_hiz", {31'd0, ok},  32'd1);
        check("bad_qpi_err", {31'd0, err}, 32'd1);
        qpi_cmd_only(8'h66);
        check("qpi_66_rst_en", {31'd0, rst_en}, 32'd1);
        qpi_cmd_only(8'h99);
        check("qpi_99_err", {31'd0, err},      32'd0);
        check("qpi_99_qpi", {31'd0, qpi_mode}, 32'd0);

        // Async reset in the middle of a read burst.
        spi_cmd(8'h35);
        qpi_hdr(8'hEB, 24'h000010);
        for (int k = 8; k < 15; k++) slot_drive(4'd0, 1'b0);
        check("burst_slot14_oe",  {31'd0, seen_oe}, 32'd1);
        check("burst_slot14_val", {28'd0, seen_val}, 32'hA);
        @(negedge mem_clk);
        #1;
        mem_ce = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_oe",       {31'd0, dut.sio_oe}, 32'd0);
        check("arst_qpi",      {31'd0, qpi_mode},   32'd0);
        check("arst_wr_bytes", {16'd0, wr_bytes},   32'd0);
        ce_high(2);
        rst_n = 1'b1;
        ce_high(1);
        spi_cmd(8'h35);
        qpi_read(24'h000010, rd, ok);
        check("arst_mem_kept", {16'd0, rd}, 32'h0000A55A);
        check("arst_mem_oe",   {31'd0, ok}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
